// File: rtl/halt_reporter_if.sv
// Run-status link between the SoC halt outputs, the report byte stream and the
// sticky status. The slave modport is the reporter; master is the environment.
interface halt_reporter_if;
  logic        halt;
  logic [15:0] firstWord;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic        done;
  logic [1:0]  err;

  modport master (
    output halt, firstWord, outReady,
    input  outData, outValid, done, err
  );

  modport slave (
    input  halt, firstWord, outReady,
    output outData, outValid, done, err
  );
endinterface

// File: rtl/halt_reporter.sv
// Captures the first SoC halt, waits a settle window, then streams {word, count}
// MSB-first as bytes. HALT_REPORTER_CHECK_EN enables the timeout/stability checks.
module halt_reporter #(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SETTLE_CYCLES  = 5,
  parameter int CNT_W          = 32
) (
  input logic             clk,
  input logic             rst,
  halt_reporter_if.slave  bus
);

  localparam int NBYTES = 2 + CNT_W / 8;
  localparam int REC_W  = 16 + CNT_W;
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IDX_W  = $clog2(NBYTES);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] REPORT = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
`ifdef HALT_REPORTER_CHECK_EN
  localparam logic [2:0] FAULT  = 3'd4;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt, cntNext, haltCnt;
  logic [15:0]      word;
  logic [SET_W-1:0] sCnt;
  logic [IDX_W-1:0] idx;
  logic [REC_W-1:0] sh;
  logic             vld, doneR;
  logic             settleLast, xfer;

  assign cntNext    = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign settleLast = (sCnt == SET_W'(SETTLE_CYCLES - 1));
  assign xfer       = vld && bus.outReady;

  // Outgoing byte is always the top of the record shift register.
  assign bus.outData  = sh[REC_W-1 -: 8];
  assign bus.outValid = vld;
  assign bus.done     = doneR;

`ifdef HALT_REPORTER_CHECK_EN
  logic [1:0] errR;
  assign bus.err = errR;

  function automatic logic [REC_W-1:0] faultRec(input logic [1:0] code);
    return {6'b111000, code, {(REC_W-8){1'b0}}};
  endfunction
`else
  assign bus.err = 2'b00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      haltCnt <= '0;
      word    <= '0;
      sCnt    <= '0;
      idx     <= '0;
      sh      <= '0;
      vld     <= 1'b0;
      doneR   <= 1'b0;
`ifdef HALT_REPORTER_CHECK_EN
      errR    <= 2'b00;
`endif
    end else begin
      case (state)
        RUN: begin
          cnt <= cntNext;
          if (bus.halt) begin
            word    <= bus.firstWord;
            haltCnt <= cntNext;
            sCnt    <= '0;
            state   <= SETTLE;
          end
`ifdef HALT_REPORTER_CHECK_EN
          // Halt on the timeout edge still wins: this branch is only the else.
          else if (cntNext >= TO_LIM) begin
            errR  <= 2'b01;
            sh    <= faultRec(2'b01);
            vld   <= 1'b1;
            state <= FAULT;
          end
`endif
        end

        SETTLE: begin
          cnt <= cntNext;
`ifdef HALT_REPORTER_CHECK_EN
          if (!bus.halt) begin
            errR  <= 2'b10;
            sh    <= faultRec(2'b10);
            vld   <= 1'b1;
            state <= FAULT;
          end else if (bus.firstWord != word) begin
            errR  <= 2'b11;
            sh    <= faultRec(2'b11);
            vld   <= 1'b1;
            state <= FAULT;
          end else
`endif
          if (settleLast) begin
            sh    <= {word, haltCnt + CNT_W'(SETTLE_CYCLES)};
            idx   <= '0;
            vld   <= 1'b1;
            state <= REPORT;
          end else begin
            sCnt <= sCnt + SET_W'(1);
          end
        end

        REPORT: begin
          if (xfer) begin
            // Shifting past the last byte leaves outData at zero in DONE.
            sh <= sh << 8;
            if (idx == IDX_W'(NBYTES - 1)) begin
              vld   <= 1'b0;
              doneR <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

`ifdef HALT_REPORTER_CHECK_EN
        FAULT: begin
          if (xfer) begin
            sh    <= '0;
            vld   <= 1'b0;
            doneR <= 1'b1;
            state <= DONE;
          end
        end
`endif

        DONE: ;

        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_reporter.sv
// Table-driven bench for halt_reporter with a byte scoreboard; fault cases
// follow HALT_REPORTER_CHECK_EN so either build can be checked.
module tb_halt_reporter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  halt_reporter_if bus();

  halt_reporter #(
    .TIMEOUT_CYCLES(20),
    .SETTLE_CYCLES (5),
    .CNT_W         (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      name;
    int         haltAt;    // 0: never halt
    int         dropAt;    // settle cycle on which halt drops, 0: never
    int         changeAt;  // settle cycle on which firstWord changes, 0: never
    bit         toggle;    // outReady alternates 1-0-1-0
    int         nBytes;
    logic [7:0] bytes [6];
    logic       expDone;
    logic [1:0] expErr;
  } vec_t;

  int         nCmp = 0;
  int         nErr = 0;
  logic [7:0] expQ [$];
  bit         prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  vec_t       vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a byte transfers on the next edge if valid&&ready now.
  always @(negedge clk) begin
    if (!rst) begin
      if (prevStall) begin
        check("stallValid", {31'd0, bus.outValid}, 32'd1);
        check("stallData", {24'd0, bus.outData}, {24'd0, prevData});
      end
      if (bus.outValid && bus.outReady) begin
        if (expQ.size() == 0) begin
          check("extraByte", {24'd0, bus.outData}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = expQ.pop_front();
          check("byte", {24'd0, bus.outData}, {24'd0, e});
        end
      end
      check("doneEarly", {31'd0, bus.done && (expQ.size() != 0)}, 32'd0);
      prevStall = bus.outValid && !bus.outReady;
      prevData  = bus.outData;
    end
  end

  task automatic applyReset();
    rst           = 1'b1;
    bus.halt      = 1'b0;
    bus.firstWord = 16'h0000;
    bus.outReady  = 1'b0;
    expQ.delete();
    prevStall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstValid", {31'd0, bus.outValid}, 32'd0);
    check("rstData",  {24'd0, bus.outData},  32'd0);
    check("rstDone",  {31'd0, bus.done},     32'd0);
    check("rstErr",   {30'd0, bus.err},      32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives the inputs seen by edge k (edge 1 = first edge after release).
  task automatic driveEdge(input vec_t v, input int k);
    bit halted;
    halted = (v.haltAt != 0) && (k >= v.haltAt) &&
             !((v.dropAt != 0) && (k >= v.haltAt + v.dropAt));
    bus.halt = halted;
    if (v.haltAt != 0 && k >= v.haltAt)
      bus.firstWord = (v.changeAt != 0 && k >= v.haltAt + v.changeAt) ? 16'h1235 : 16'h1234;
    else
      bus.firstWord = 16'h00FF ^ 16'(k);
    bus.outReady = v.toggle ? (k % 2 == 1) : 1'b1;
  endtask

  task automatic runCase(input vec_t v);
    applyReset();
    for (int i = 0; i < v.nBytes; i++) expQ.push_back(v.bytes[i]);
    for (int k = 1; k <= 60; k++) begin
      driveEdge(v, k);
      @(posedge clk);
      #1;
    end
    check({v.name, ".done"},   {31'd0, bus.done},     {31'd0, v.expDone});
    check({v.name, ".err"},    {30'd0, bus.err},      {30'd0, v.expErr});
    check({v.name, ".valid"},  {31'd0, bus.outValid}, 32'd0);
    check({v.name, ".missing"}, expQ.size(),          32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{"halt12",    12, 0, 0, 1'b0, 6, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h11}, 1'b1, 2'b00};
    vecs[1] = '{"halt12bp",  12, 0, 0, 1'b1, 6, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h11}, 1'b1, 2'b00};
    vecs[2] = '{"haltOnTo",  20, 0, 0, 1'b0, 6, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h19}, 1'b1, 2'b00};
`ifdef HALT_REPORTER_CHECK_EN
    vecs[3] = '{"timeout",    0, 0, 0, 1'b0, 1, '{8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 2'b01};
    vecs[4] = '{"haltDrop",   5, 3, 0, 1'b0, 1, '{8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 2'b10};
    vecs[5] = '{"wordChg",    5, 0, 3, 1'b0, 1, '{8'hE3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 2'b11};
`else
    vecs[3] = '{"noHalt",     0, 0, 0, 1'b0, 0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 2'b00};
    vecs[4] = '{"haltDrop",   5, 3, 0, 1'b0, 6, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h0A}, 1'b1, 2'b00};
    vecs[5] = '{"wordChg",    5, 0, 3, 1'b0, 6, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h0A}, 1'b1, 2'b00};
`endif

    bus.halt = 1'b0;
    bus.firstWord = 16'h0000;
    bus.outReady = 1'b0;

    for (int c = 0; c < 6; c++) runCase(vecs[c]);

    // Reset mid-record: abandon after the 3rd byte, then a fresh halt at count 4.
    v = vecs[0];
    applyReset();
    for (int i = 0; i < 6; i++) expQ.push_back(v.bytes[i]);
    for (int k = 1; k <= 20; k++) begin
      driveEdge(v, k);
      @(posedge clk);
      #1;
    end
    check("midRst.left", expQ.size(), 32'd3);
    check("midRst.validBefore", {31'd0, bus.outValid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("midRst.valid", {31'd0, bus.outValid}, 32'd0);
    check("midRst.data",  {24'd0, bus.outData},  32'd0);
    check("midRst.done",  {31'd0, bus.done},     32'd0);
    check("midRst.err",   {30'd0, bus.err},      32'd0);

    v = '{"rehalt4", 4, 0, 0, 1'b0, 6, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h09}, 1'b1, 2'b00};
    runCase(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/halt_reporter.md
# halt_reporter

Synthesizable run-status monitor placed directly downstream of `dut_soc`. It watches the SoC `halt` and `firstWord` outputs, captures the first halt, and checks that the halted state stays stable for a settle window. It then streams a fixed-format result record (halted word plus cycle count) over a byte-wide valid/ready interface to a host link, or reports a fault code. It lets hardware runs produce the same result record that simulation writes to `sim_output`.

## Interface
- `TIMEOUT_CYCLES`, 10000: cycle count at which a missing halt becomes a fault.
- `SETTLE_CYCLES`, 5: cycles halt must remain stable after capture; must be ≥1.
- `CNT_W`, 32: cycle counter width; must be a multiple of 8 and ≥16.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `halt`  in  1  SoC halt indication.
- `firstWord`  in  16  SoC word reported at halt.
- `outData`  out  8  report byte.
- `outValid`  out  1  `outData` is valid.
- `outReady`  in  1  consumer accepts the byte.
- `done`  out  1  sticky; record fully transferred.
- `err`  out  2  sticky fault code: 00 none, 01 timeout, 10 halt dropped, 11 word changed.

## Operation
- Reset values: all outputs 0; state RUN; cycle counter 0; captured word 0.
- The cycle counter increments on every clock in RUN and SETTLE. It saturates at all-ones. The first edge after reset release gives count 1.
- **RUN**
  - `halt`=1: capture `firstWord` into `word`, capture the post-increment count into `haltCnt`, clear the settle counter, go to SETTLE.
  - Else, if the count reaches `TIMEOUT_CYCLES`: `err`←01, go to FAULT.
- **SETTLE**
  - Each cycle, check the inputs. If `halt`=0: `err`←10, go to FAULT. Else, if `firstWord`≠`word`: `err`←11, go to FAULT. Halt-dropped takes priority.
  - After `SETTLE_CYCLES` clean cycles, go to REPORT. The reported count is `haltCnt+SETTLE_CYCLES`.
- **REPORT**
  - Sends `2+CNT_W/8` bytes, MSB first: `word[15:8]`, `word[7:0]`, then the count bytes.
  - After the last byte is accepted: `done`←1, go to DONE.
- **FAULT**
  - Sends one byte `{6'b111000, err}`.
  - When it is accepted: `done`←1, go to DONE.
- **DONE**
  - Terminal state. `outValid`=0, and `done` and `err` are held.
  - Inputs are ignored. Only `rst` exits DONE.
- Handshake rules:
  - A byte transfers on a clock where `outValid`&&`outReady`.
  - While `outValid`=1 and the byte has not transferred, `outData` is stable and `outValid` is not withdrawn.
  - `outReady` may change freely. Back-pressure stalls the stream indefinitely without loss.
- Inputs are not checked once REPORT or FAULT is entered.
- `rst` asserted in any state returns the block to its reset values immediately, including mid-transfer. A partially sent record is abandoned.

## Timing
- Halt is sampled at clock edge N (count becomes C). SETTLE occupies edges N+1 … N+SETTLE_CYCLES. `outValid` rises after edge N+SETTLE_CYCLES.
- With `outReady` held at 1: one byte per cycle. `done` rises on the edge that accepts the last byte, so a full record takes 6 cycles at `CNT_W`=32.
- Timeout: `err`=01 and `outValid`=1 become visible after the edge on which the count reaches `TIMEOUT_CYCLES`.
- `halt` asserted on the same edge the count reaches `TIMEOUT_CYCLES`: the halt wins and there is no fault.
- Zero-latency paths: `outValid` and `outData` are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `HALT_REPORTER_CHECK_EN`.
- Defined: timeout and settle stability checks are active as described above.
- Undefined:
  - The FAULT state and the checks are not compiled.
  - `err` is tied to 00.
  - RUN waits indefinitely for halt.
  - SETTLE only counts `SETTLE_CYCLES` and then goes to REPORT regardless of inputs.

## Test plan
- Halt at count 12 with `firstWord`=0x1234 held, `outReady`=1: bytes 12 34 00 00 00 11 are sent, then `done`=1 and `err`=00.
- Same stimulus with `outReady` toggling 1-0-1-0: identical byte sequence, each byte stable across stalls, `done` only after the 6th byte is accepted.
- No halt, `TIMEOUT_CYCLES`=20: after count 20, byte 0xE1 is sent, `done`=1, `err`=01. Undefined-macro build: no output, `done` stays 0.
- Halt at count 5, then `halt`=0 at settle cycle 3: byte 0xE2, `err`=10. Variant with `firstWord` changing to 0x1235 while halted: byte 0xE3, `err`=11.
- Halt on count 20 with `TIMEOUT_CYCLES`=20: a normal record with count 25, `err`=00.
- `rst` asserted after the 3rd report byte: all outputs drop to 0 asynchronously. After release, a halt at count 4 produces a fresh record ending in count byte 0x09.
